// File: rtl/branch_predict_unit_if.sv
// branch_predict_unit_if
//   Groups the fetch-side lookup, the execute-side resolution and the
//   statistics outputs of the branch predictor.
//   Parameter: XLEN - PC / address width.
//   Modports:
//     master - pipeline side: drives fetch_pc and the ex_* resolution fields,
//              receives predict_taken, hit, flush, miss_address and the counts.
//     slave  - predictor side (branch_predict_unit).
interface branch_predict_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] fetch_pc;
  logic            predict_taken;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic            ex_pred;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic [XLEN-1:0] ex_fallthrough;
  logic            hit;
  logic            flush;
  logic [XLEN-1:0] miss_address;
  logic [31:0]     branch_count;
  logic [31:0]     miss_count;

  modport master (
    output fetch_pc, ex_valid, ex_pc, ex_pred, ex_taken, ex_target, ex_fallthrough,
    input  predict_taken, hit, flush, miss_address, branch_count, miss_count
  );

  modport slave (
    input  fetch_pc, ex_valid, ex_pc, ex_pred, ex_taken, ex_target, ex_fallthrough,
    output predict_taken, hit, flush, miss_address, branch_count, miss_count
  );
endinterface

// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Direct-mapped table of saturating counters indexed by the low PC bits
//   (no tags, so aliasing PCs share a counter). Fetch reads the counter MSB
//   combinationally; the execute stage resolves branches, reports hit/flush
//   and the redirect address combinationally, and trains the table on the
//   next rising edge.
//   Parameters: XLEN (address width), ENTRIES (power of two, >= 2),
//               CTR_BITS (counter width, >= 1).
//   Ports:
//     clk - clock, rising edge
//     rst - synchronous active-high reset (table to weakly not-taken,
//           counts to 0; wins over a same-cycle update)
//     bp  - branch_predict_unit_if.slave, see the interface file
//   Optional feature: define BP_STATS_EN to build saturating 32-bit
//   resolved-branch and misprediction counters; otherwise both counts
//   are tied to 0.
module branch_predict_unit #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_predict_unit_if.slave  bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic [CTR_BITS-1:0] r_table [ENTRIES];

  logic [IDX_W-1:0] w_fetch_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic             w_flush;
  logic             w_unused;

  assign w_fetch_idx = bp.fetch_pc[IDX_W-1:0];
  assign w_ex_idx    = bp.ex_pc[IDX_W-1:0];
  // Upper PC bits are deliberately ignored (no tag check).
  assign w_unused    = ^{bp.fetch_pc[XLEN-1:IDX_W], bp.ex_pc[XLEN-1:IDX_W]};

  // Read returns the pre-update value when fetch and update hit one index.
  assign bp.predict_taken = r_table[w_fetch_idx][CTR_BITS-1];

  assign w_flush         = bp.ex_valid & (bp.ex_pred ^ bp.ex_taken);
  assign bp.flush        = w_flush;
  assign bp.hit          = bp.ex_valid & ~(bp.ex_pred ^ bp.ex_taken);
  // Predicted not-taken but taken -> go to target; the reverse -> fall through.
  assign bp.miss_address = bp.ex_pred ? bp.ex_fallthrough : bp.ex_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i] <= CTR_RST;
      end
    end else if (bp.ex_valid) begin
      if (bp.ex_taken) begin
        if (r_table[w_ex_idx] != CTR_MAX) begin
          r_table[w_ex_idx] <= r_table[w_ex_idx] + CTR_BITS'(1);
        end
      end else begin
        if (r_table[w_ex_idx] != '0) begin
          r_table[w_ex_idx] <= r_table[w_ex_idx] - CTR_BITS'(1);
        end
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_branch_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_count <= '0;
      r_miss_count   <= '0;
    end else begin
      if (bp.ex_valid && (r_branch_count != 32'hFFFF_FFFF)) begin
        r_branch_count <= r_branch_count + 32'd1;
      end
      if (w_flush && (r_miss_count != 32'hFFFF_FFFF)) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign bp.branch_count = r_branch_count;
  assign bp.miss_count   = r_miss_count;
`else
  assign bp.branch_count = '0;
  assign bp.miss_count   = '0;
`endif
endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter XLEN, default 32: PC and address width in bits.
REQ-002 Parameter ENTRIES, default 16: number of prediction-table entries; power of two, at least 2; IDX_W = log2(ENTRIES).
REQ-003 Parameter CTR_BITS, default 2: width of each saturating counter; at least 1.
REQ-004 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 Port rst  input  1: reset, synchronous, active-high.
REQ-006 Port fetch_pc  input  XLEN: word-addressed PC of the instruction being fetched.
REQ-007 Port predict_taken  output  1: prediction for fetch_pc (1 = taken).
REQ-008 Port ex_valid  input  1: execute stage holds a resolved conditional branch this cycle.
REQ-009 Port ex_pc  input  XLEN: PC of the resolving branch.
REQ-010 Port ex_pred  input  1: prediction carried down the pipeline with that branch.
REQ-011 Port ex_taken  input  1: actual outcome (equality/zero result).
REQ-012 Port ex_target  input  XLEN: taken target (pc + imm).
REQ-013 Port ex_fallthrough  input  XLEN: not-taken recovery address.
REQ-014 Port hit  output  1: prediction correct.
REQ-015 Port flush  output  1: misprediction, redirect fetch.
REQ-016 Port miss_address  output  XLEN: redirect address.
REQ-017 Port branch_count  output  32: resolved-branch count.
REQ-018 Port miss_count  output  32: misprediction count.

Function
REQ-019 Table: ENTRIES counters of CTR_BITS bits; index = pc[IDX_W-1:0].
REQ-020 predict_taken = MSB of counter at fetch_pc index; combinational read, same cycle.
REQ-021 hit = ex_valid & (ex_pred == ex_taken); combinational.
REQ-022 flush = ex_valid & (ex_pred != ex_taken); combinational.
REQ-023 miss_address = ex_target when ex_pred = 0, ex_fallthrough when ex_pred = 1; combinational, don't-care when flush = 0.
REQ-024 ex_valid = 0: hit = 0, flush = 0, no table or counter change.
REQ-025 On clock edge with ex_valid = 1: counter at ex_pc index increments when ex_taken = 1, decrements when ex_taken = 0.
REQ-026 Counters saturate at 0 and 2^CTR_BITS-1; no wrap-around.
REQ-027 Same-cycle fetch read and update of one index: predict_taken reflects the pre-update value; the new value is visible the next cycle.
REQ-028 Aliasing: PCs with equal low IDX_W bits share one counter; no tag check.
REQ-029 Table update latency: one cycle; outputs of REQ-021..023 have zero latency.

Reset
REQ-030 rst = 1 at a clock edge sets every counter to 2^(CTR_BITS-1)-1 (weakly not-taken; 01 for CTR_BITS = 2).
REQ-031 rst = 1 clears branch_count and miss_count to 0.
REQ-032 rst has priority over a same-cycle update; the update is discarded.
REQ-033 After reset, predict_taken = 0 for every PC.

Configuration
REQ-034 Macro BP_STATS_EN defined: branch_count increments on each clock with ex_valid = 1; miss_count increments on each clock with flush = 1; both saturate at 32'hFFFFFFFF.
REQ-035 Macro BP_STATS_EN undefined: branch_count and miss_count are constant 0, no counter logic is built, and the ports remain present.

Verification
REQ-036 Reset, then fetch_pc = 0..15 -> predict_taken = 0 for all; counters all read back 01.
REQ-037 ex_valid = 1, ex_pc = 5, ex_taken = 1 for 3 cycles -> counter[5] goes 01→10→11→11; predict_taken for fetch_pc = 5 (and 21) is 1 from the cycle after the first update.
REQ-038 ex_pred = 0, ex_taken = 1, ex_target = 0x40, ex_fallthrough = 0x08 -> flush = 1, hit = 0, miss_address = 0x40; with ex_pred = 1, ex_taken = 0 -> miss_address = 0x08.
REQ-039 fetch_pc = ex_pc = 3, counter 01, ex_taken = 1 in the same cycle -> predict_taken = 0 that cycle, 1 the next.
REQ-040 rst = 1 asserted in the same cycle as an update to index 7 -> counter[7] = 01 afterwards; with BP_STATS_EN, both counts = 0.
REQ-041 With BP_STATS_EN: 10 resolutions with 4 mispredictions -> branch_count = 10, miss_count = 4; without BP_STATS_EN, both read 0.
